mips_phase_gen: RTL and testbench
=================================

# mips_phase_gen

Parametrised multi-phase enable generator for the MIPS pipeline datapath. It derives NUM_PHASES non-overlapping one-hot phase enables from a single clock, replacing the hand-built two-phase clk2/clk3 waveform. Each phase has a programmable pulse width and trailing gap. The generator also supports a round budget with a done flag, stall, and abort. It sits between the top-level clock/reset and the stage registers of the datapath.

## Interface
- NUM_PHASES, 2: number of phase enables; must be ≥ 2.
- PULSE_CYCLES, 1: clk cycles each phase enable stays high; must be ≥ 1.
- GAP_CYCLES, 1: all-low clk cycles after each pulse; 0 is legal.
- CNT_W, 16: width of the round budget and round counter.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a run; sampled in IDLE or DONE only.
- stop  in  1  abort the run; return to IDLE.
- stall  in  1  freeze sequencing while high.
- budget  in  CNT_W  rounds to run; 0 = free-run. Latched on an accepted start.
- phase_en  out  NUM_PHASES  one-hot phase enable; all zero outside a pulse.
- phase_idx  out  clog2(NUM_PHASES)  index of the current or last phase.
- round_cnt  out  CNT_W  completed full rounds in the current run.
- running  out  1  high in PULSE or GAP.
- done  out  1  high in DONE; sticky.

## Operation
- States:
  - IDLE
  - PULSE: phase_en = 1<<phase_idx.
  - GAP: phase_en = 0.
  - DONE
- IDLE/DONE + start → PULSE. On this transition:
  - phase_idx=0, round_cnt=0, sub-counter=0.
  - budget is latched.
- PULSE: the sub-counter counts to PULSE_CYCLES-1, then goes to GAP. If GAP_CYCLES=0, it skips GAP and performs the GAP-exit action instead.
- GAP exit, after GAP_CYCLES cycles:
  - If phase_idx < NUM_PHASES-1: phase_idx+1, then PULSE.
  - Otherwise a round ends: phase_idx=0 and round_cnt+1.
  - If latched budget ≠ 0 and the new round_cnt == budget: go to DONE and hold phase_idx at NUM_PHASES-1.
  - Else: go to PULSE.
- Free-run round_cnt wraps from 2^CNT_W-1 to 0 silently.
- stall (PULSE or GAP):
  - All counters and state hold.
  - phase_en is forced to 0 in the same cycle (combinational gate on the registered enable).
  - Sequencing resumes exactly where it left off, with the remaining pulse/gap cycles unchanged.
- stop (any state) → IDLE next edge; done=0, round_cnt holds its last value. stop has priority over stall and start.
- start while running is ignored. start and stop in the same cycle: stop wins.
- rst has priority over everything. Reset values:
  - state=IDLE, phase_en=0, phase_idx=0, round_cnt=0, running=0, done=0.

## Timing
- start sampled at edge t → phase_en[0]=1 after edge t+1 (one-cycle latency); running rises on the same edge.
- Each phase is high for exactly PULSE_CYCLES cycles, then low for GAP_CYCLES cycles.
- Round period = NUM_PHASES×(PULSE_CYCLES+GAP_CYCLES) cycles.
- Defaults (2,1,1) give the pattern p0,0,p1,0 with period 4, i.e. the legacy clk2/clk3 pattern.
- At most one bit of phase_en is high in any cycle; there are never two adjacent phases without GAP when GAP_CYCLES ≥ 1.
- done rises on the edge that ends the last GAP, at the same edge running falls.
- Budget B, no stall: done rises B×period cycles after phase_en[0] first rises.
- stall and stop act on the edge that samples them. The stall gating of phase_en is immediate (same cycle).

## Configuration
- PHASE_GEN_STEP_EN defined: adds two inputs, step_mode (1) and step (1), and a HOLD state.
  - With step_mode=1, each GAP exit (or pulse end when GAP_CYCLES=0) enters HOLD instead of the next PULSE.
  - In HOLD: phase_en=0 and running=1.
  - A step pulse advances to the next PULSE; if the budget is exhausted it goes to DONE.
  - stop leaves HOLD to IDLE.
  - With step_mode=0, behaviour is identical to the macro-undefined build.
- PHASE_GEN_STEP_EN undefined: no step ports and no HOLD state. Behaviour is exactly as described above.

## Test plan
- Reset, then start with defaults and budget=3 → phase_en = 01,00,10,00 repeated 3 times starting the cycle after start. done=1 at cycle 13 after start; round_cnt=3.
- NUM_PHASES=4, PULSE_CYCLES=2, GAP_CYCLES=0, budget=0 → one-hot 0001,0001,0010,0010,0100,0100,1000,1000 repeating, never two bits set. round_cnt increments every 8 cycles and wraps past 2^CNT_W-1.
- Defaults, stall raised for 5 cycles mid-pulse of phase 1 → phase_en=0 for those 5 cycles. Phase 1 then resumes for its remaining cycle; done is delayed by exactly 5 cycles.
- stop asserted in GAP of round 2 together with start → IDLE next edge, running=0, done=0, round_cnt=1. A later start restarts from phase 0 with round_cnt=0.
- rst asserted during PULSE → all outputs 0 on the next edge. start in the same cycle as rst is ignored.
- PHASE_GEN_STEP_EN, step_mode=1 → after each phase the block waits in HOLD with phase_en=0. Each step pulse releases exactly one further phase; budget=1 with 2 phases reaches done after the second step.

Source files
------------

// File: rtl/mips_phase_gen_if.sv
// mips_phase_gen_if: control and status bundle of the multi-phase enable
// generator. The master side (sequencer / test driver) drives the run
// controls; the slave side (mips_phase_gen) returns the phase enables and
// run status. Optional build macro PHASE_GEN_STEP_EN adds single-step controls.

interface mips_phase_gen_if #(
    parameter int NUM_PHASES = 2,
    parameter int CNT_W      = 16
);
    localparam int IDX_W = $clog2(NUM_PHASES);

    logic                  i_start;
    logic                  i_stop;
    logic                  i_stall;
    logic [CNT_W-1:0]      i_budget;
`ifdef PHASE_GEN_STEP_EN
    logic                  i_step_mode;
    logic                  i_step;
`endif
    logic [NUM_PHASES-1:0] o_phase_en;
    logic [IDX_W-1:0]      o_phase_idx;
    logic [CNT_W-1:0]      o_round_cnt;
    logic                  o_running;
    logic                  o_done;

`ifdef PHASE_GEN_STEP_EN
    modport master (
        output i_start, i_stop, i_stall, i_budget, i_step_mode, i_step,
        input  o_phase_en, o_phase_idx, o_round_cnt, o_running, o_done
    );
    modport slave (
        input  i_start, i_stop, i_stall, i_budget, i_step_mode, i_step,
        output o_phase_en, o_phase_idx, o_round_cnt, o_running, o_done
    );
`else
    modport master (
        output i_start, i_stop, i_stall, i_budget,
        input  o_phase_en, o_phase_idx, o_round_cnt, o_running, o_done
    );
    modport slave (
        input  i_start, i_stop, i_stall, i_budget,
        output o_phase_en, o_phase_idx, o_round_cnt, o_running, o_done
    );
`endif

endinterface

// File: rtl/mips_phase_gen.sv
// mips_phase_gen: NUM_PHASES non-overlapping one-hot phase enables derived
// from one clock, each high for PULSE_CYCLES and followed by GAP_CYCLES of
// all-low. Runs for a latched round budget (0 = free-run) with stall, stop and
// a sticky done flag.
// Build option: define PHASE_GEN_STEP_EN to add step_mode/step inputs and a
// HOLD state that parks the generator after every phase until a step pulse.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | no run; waiting for start
// S_PULSE | phase enable r_idx is high, r_tmr counts remaining pulse cycles
// S_GAP   | all enables low, r_tmr counts remaining gap cycles
// S_DONE  | budget consumed; done held until start or stop
// S_HOLD  | (step build only) parked between phases until step

module mips_phase_gen #(
    parameter int NUM_PHASES   = 2,
    parameter int PULSE_CYCLES = 1,
    parameter int GAP_CYCLES   = 1,
    parameter int CNT_W        = 16
) (
    input  logic           i_clk,
    input  logic           i_rst,
    mips_phase_gen_if.slave io_bus
);

    localparam int IDX_W   = $clog2(NUM_PHASES);
    localparam int TMR_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [TMR_W-1:0] PULSE_LOAD = TMR_W'(PULSE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_PHASES - 1);
    localparam bit               HAS_GAP    = (GAP_CYCLES > 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PULSE,
        S_GAP,
`ifdef PHASE_GEN_STEP_EN
        S_HOLD,
`endif
        S_DONE
    } state_t;

    state_t                r_state;
    logic [TMR_W-1:0]      r_tmr;
    logic [IDX_W-1:0]      r_idx;
    logic [CNT_W-1:0]      r_round;
    logic [CNT_W-1:0]      r_budget;
    logic [NUM_PHASES-1:0] r_phase_en;
    logic                  r_running;
    logic                  r_done;

    logic                  w_seg_end;
    logic                  w_last_phase;
    logic [IDX_W-1:0]      w_next_idx;
    logic [CNT_W-1:0]      w_next_round;
    logic                  w_budget_hit;
    logic [NUM_PHASES-1:0] w_next_onehot;
`ifdef PHASE_GEN_STEP_EN
    logic [NUM_PHASES-1:0] w_cur_onehot;
    logic                  w_hold_done;
`endif

    // Down-counter reaches terminal count on the last cycle of a pulse or gap.
    assign w_seg_end     = (r_tmr == '0);
    assign w_last_phase  = (r_idx == LAST_IDX);
    assign w_next_idx    = w_last_phase ? '0 : r_idx + IDX_W'(1);
    assign w_next_round  = w_last_phase ? r_round + CNT_W'(1) : r_round;
    // Budget is only consumed when a full round closes; a zero budget never matches.
    assign w_budget_hit  = w_last_phase && (r_budget != '0) && (w_next_round == r_budget);
    assign w_next_onehot = {{(NUM_PHASES-1){1'b0}}, 1'b1} << w_next_idx;
`ifdef PHASE_GEN_STEP_EN
    assign w_cur_onehot  = {{(NUM_PHASES-1){1'b0}}, 1'b1} << r_idx;
    // In HOLD the round count has already advanced, so an exhausted budget shows here.
    assign w_hold_done   = (r_budget != '0) && (r_round == r_budget);
`endif

    // Phase sequencer: state, timers, counters and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_tmr      <= '0;
            r_idx      <= '0;
            r_round    <= '0;
            r_budget   <= '0;
            r_phase_en <= '0;
            r_running  <= 1'b0;
            r_done     <= 1'b0;
        end else if (io_bus.i_stop) begin
            r_state    <= S_IDLE;
            r_phase_en <= '0;
            r_running  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (io_bus.i_start) begin
                        r_state    <= S_PULSE;
                        r_tmr      <= PULSE_LOAD;
                        r_idx      <= '0;
                        r_round    <= '0;
                        r_budget   <= io_bus.i_budget;
                        r_phase_en <= {{(NUM_PHASES-1){1'b0}}, 1'b1};
                        r_running  <= 1'b1;
                        r_done     <= 1'b0;
                    end
                end
                S_PULSE, S_GAP: begin
                    if (!io_bus.i_stall) begin
                        if (!w_seg_end) begin
                            r_tmr <= r_tmr - TMR_W'(1);
                        end else if ((r_state == S_PULSE) && HAS_GAP) begin
                            r_state    <= S_GAP;
                            r_tmr      <= GAP_LOAD;
                            r_phase_en <= '0;
                        end else begin
                            // End of a gap (or of a pulse when there is no gap).
                            r_idx   <= w_next_idx;
                            r_round <= w_next_round;
`ifdef PHASE_GEN_STEP_EN
                            if (io_bus.i_step_mode) begin
                                r_state    <= S_HOLD;
                                r_phase_en <= '0;
                            end else
`endif
                            if (w_budget_hit) begin
                                r_state    <= S_DONE;
                                r_idx      <= LAST_IDX;
                                r_phase_en <= '0;
                                r_running  <= 1'b0;
                                r_done     <= 1'b1;
                            end else begin
                                r_state    <= S_PULSE;
                                r_tmr      <= PULSE_LOAD;
                                r_phase_en <= w_next_onehot;
                            end
                        end
                    end
                end
`ifdef PHASE_GEN_STEP_EN
                S_HOLD: begin
                    if (io_bus.i_step) begin
                        if (w_hold_done) begin
                            r_state    <= S_DONE;
                            r_idx      <= LAST_IDX;
                            r_running  <= 1'b0;
                            r_done     <= 1'b1;
                        end else begin
                            r_state    <= S_PULSE;
                            r_tmr      <= PULSE_LOAD;
                            r_phase_en <= w_cur_onehot;
                        end
                    end
                end
`endif
                default: begin
                    r_state    <= S_IDLE;
                    r_phase_en <= '0;
                    r_running  <= 1'b0;
                    r_done     <= 1'b0;
                end
            endcase
        end
    end

    // Stall masks the enables in the same cycle; the registered enable is
    // untouched so the pulse picks up where it left off.
    assign io_bus.o_phase_en  = r_phase_en & {NUM_PHASES{~io_bus.i_stall}};
    assign io_bus.o_phase_idx = r_idx;
    assign io_bus.o_round_cnt = r_round;
    assign io_bus.o_running   = r_running;
    assign io_bus.o_done      = r_done;

endmodule

// File: tb/tb_mips_phase_gen.sv
// tb_mips_phase_gen: two generator configurations (legacy 2/1/1 and a
// 4-phase gapless one with a narrow round counter) driven by shared control
// stimulus. A reference model tracks each run as a count of effective
// (non-stalled) cycles and derives the expected outputs arithmetically;
// expectations are queued per cycle and a negedge monitor compares them.

module tb_mips_phase_gen;

    localparam int A_N = 2, A_PC = 1, A_GC = 1, A_CW = 16;
    localparam int B_N = 4, B_PC = 2, B_GC = 0, B_CW = 4;

    typedef struct {
        int     mode;   // 0 idle, 1 running, 2 done
        longint pos;    // effective cycles since the run began
        longint bud;
        int     idx;
        longint rnd;
    } mst_t;

    typedef struct {
        int     pe;
        int     idx;
        longint rnd;
        bit     run;
        bit     dn;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            d_rst   = 1'b1;
    logic            d_start = 1'b0;
    logic            d_stop  = 1'b0;
    logic            d_stall = 1'b0;
    logic [A_CW-1:0] d_ba    = '0;
    logic [B_CW-1:0] d_bb    = '0;

    mips_phase_gen_if #(.NUM_PHASES(A_N), .CNT_W(A_CW)) ifa ();
    mips_phase_gen_if #(.NUM_PHASES(B_N), .CNT_W(B_CW)) ifb ();

    assign ifa.i_start  = d_start;
    assign ifa.i_stop   = d_stop;
    assign ifa.i_stall  = d_stall;
    assign ifa.i_budget = d_ba;
    assign ifb.i_start  = d_start;
    assign ifb.i_stop   = d_stop;
    assign ifb.i_stall  = d_stall;
    assign ifb.i_budget = d_bb;
`ifdef PHASE_GEN_STEP_EN
    assign ifa.i_step_mode = 1'b0;
    assign ifa.i_step      = 1'b0;
    assign ifb.i_step_mode = 1'b0;
    assign ifb.i_step      = 1'b0;
`endif

    mips_phase_gen #(.NUM_PHASES(A_N), .PULSE_CYCLES(A_PC), .GAP_CYCLES(A_GC), .CNT_W(A_CW)) dut_a (
        .i_clk (clk),
        .i_rst (d_rst),
        .io_bus(ifa)
    );

    mips_phase_gen #(.NUM_PHASES(B_N), .PULSE_CYCLES(B_PC), .GAP_CYCLES(B_GC), .CNT_W(B_CW)) dut_b (
        .i_clk (clk),
        .i_rst (d_rst),
        .io_bus(ifb)
    );

    exp_t q_a[$];
    exp_t q_b[$];
    mst_t m_a = '{mode: 0, pos: 0, bud: 0, idx: 0, rnd: 0};
    mst_t m_b = '{mode: 0, pos: 0, bud: 0, idx: 0, rnd: 0};
    int   n_vec = 0;
    int   n_err = 0;

    // Model one clock edge given the inputs that edge sampled.
    function automatic mst_t adv(mst_t s, int n, int pc, int gc, int cw,
                                 bit r, bit st, bit sp, bit sl, longint bin);
        longint p;
        p = longint'(n * (pc + gc));
        if (r) begin
            s.mode = 0; s.idx = 0; s.rnd = 0;
            return s;
        end
        if (sp) begin
            s.mode = 0;
            return s;
        end
        if (s.mode != 1) begin
            if (st) begin
                s.mode = 1; s.pos = 0; s.bud = bin;
            end
        end else if (!sl) begin
            s.pos++;
            if (s.bud != 0 && s.pos == s.bud * p) begin
                s.mode = 2; s.idx = n - 1; s.rnd = s.bud;
            end
        end
        if (s.mode == 1) begin
            s.idx = int'((s.pos % p) / longint'(pc + gc));
            s.rnd = (s.pos / p) % (64'd1 << cw);
        end
        return s;
    endfunction

    function automatic exp_t pred(mst_t s, int n, int pc, int gc, bit sl);
        exp_t e;
        e.pe  = 0;
        if (s.mode == 1 && !sl && ((s.pos % longint'(n * (pc + gc))) % longint'(pc + gc)) < longint'(pc))
            e.pe = 1 << s.idx;
        e.idx = s.idx;
        e.rnd = s.rnd;
        e.run = (s.mode == 1);
        e.dn  = (s.mode == 2);
        return e;
    endfunction

    task automatic check(input string name, input int pe, input int idx, input longint rnd,
                         input bit run, input bit dn, input exp_t e);
        n_vec++;
        if (pe != e.pe || idx != e.idx || rnd != e.rnd || run != e.run || dn != e.dn) begin
            n_err++;
            $display("FAIL %s @%0t: got pe=%0h idx=%0d rnd=%0d run=%0b done=%0b, want pe=%0h idx=%0d rnd=%0d run=%0b done=%0b",
                     name, $time, pe, idx, rnd, run, dn, e.pe, e.idx, e.rnd, e.run, e.dn);
        end
    endtask

    // Monitor: compare whatever the DUTs present against queued expectations.
    always @(negedge clk) begin
        exp_t e;
        if (q_a.size() > 0) begin
            e = q_a.pop_front();
            check("cfgA", int'(ifa.o_phase_en), int'(ifa.o_phase_idx), longint'(ifa.o_round_cnt),
                  ifa.o_running, ifa.o_done, e);
        end
        if (q_b.size() > 0) begin
            e = q_b.pop_front();
            check("cfgB", int'(ifb.o_phase_en), int'(ifb.o_phase_idx), longint'(ifb.o_round_cnt),
                  ifb.o_running, ifb.o_done, e);
        end
    end

    // One cycle: advance models across the edge, then drive new inputs and
    // queue what the DUTs should show for the coming cycle.
    task automatic cyc(input bit r, input bit st, input bit sp, input bit sl,
                       input int ba, input int bb);
        @(posedge clk);
        #1;
        m_a = adv(m_a, A_N, A_PC, A_GC, A_CW, d_rst, d_start, d_stop, d_stall, longint'(d_ba));
        m_b = adv(m_b, B_N, B_PC, B_GC, B_CW, d_rst, d_start, d_stop, d_stall, longint'(d_bb));
        d_rst   = r;
        d_start = st;
        d_stop  = sp;
        d_stall = sl;
        d_ba    = A_CW'(ba);
        d_bb    = B_CW'(bb);
        q_a.push_back(pred(m_a, A_N, A_PC, A_GC, sl));
        q_b.push_back(pred(m_b, B_N, B_PC, B_GC, sl));
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(0, 0, 0, 0, 7, 5);
    endtask

    initial begin
        // Reset with start held high: start must be ignored.
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 3, 2);
        idle(2);

        // Budget 3 on the legacy config; budget changes mid-run must not matter.
        cyc(0, 1, 0, 0, 3, 2);
        idle(16);

        // Restart from DONE, stall 5 cycles while phase 1 is pulsing.
        cyc(0, 1, 0, 0, 3, 0);
        idle(2);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 7, 5);
        idle(20);

        // stop together with start in a gap of the second round.
        cyc(0, 1, 0, 0, 5, 0);
        idle(5);
        cyc(0, 1, 1, 0, 5, 0);
        idle(3);
        cyc(0, 1, 0, 0, 2, 1);
        idle(6);

        // Reset during a pulse, with start in the same cycle.
        cyc(1, 1, 0, 0, 2, 1);
        idle(3);

        // Long free run: narrow round counter wraps.
        cyc(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++) cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0, 0);
        idle(2);

        // Randomised control traffic.
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom % 400) == 0, ($urandom % 16) == 0, ($urandom % 50) == 0,
                ($urandom % 5) == 0, int'($urandom % 5), int'($urandom % 3));
        end
        cyc(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;

        n_vec++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d/%0d pending, want 0/0", q_a.size(), q_b.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
